// File: rtl/pokey_cmd_seq.sv
// POKEY command sequencer: fetches 16-bit command words from a synchronous ROM
// and issues POKEY register write cycles, paced by a frame tick, with an
// automatic AUDC mute sequence on stop.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | bus inactive, waiting for start (or stop -> mute)
// FETCH  | ROM address presented; ROM data valid next cycle
// DECODE | command word on rom_data, dispatch on opcode
// WRITE  | single-cycle write strobe on the POKEY bus
// WAIT   | counting frame ticks down to terminal count
// MUTE   | four strobes to AUDC1..4 separated by idle cycles
module pokey_cmd_seq #(
    parameter int          ROM_AW   = 8,
    parameter logic [7:0]  MUTE_VAL = 8'h00
) (
    input  logic              phi2,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic [ROM_AW-1:0] song_base,
    input  logic              tick,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              r_w_n,
    output logic              cs0_n,
    output logic              cs1_n,
    output logic [3:0]        a,
    output logic [7:0]        d_out,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_WRITE,
        S_WAIT,
        S_MUTE
    } state_t;

    state_t              state;
    logic [ROM_AW-1:0]   pc;
    logic [7:0]          cnt;
    logic [2:0]          mute_step;

    // Bits [13:12] of the command word carry no meaning.
    logic unused_bits;
    assign unused_bits = ^rom_data[13:12];

    // The ROM address is the pc register itself: pc is only ever loaded on
    // the edge that enters FETCH, so the address is stable throughout FETCH
    // and the registered ROM output lands exactly in DECODE.
    assign rom_addr = pc;

    // Sequencer FSM with registered bus outputs.
    always_ff @(posedge phi2 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            pc        <= '0;
            cnt       <= '0;
            mute_step <= '0;
            cs0_n     <= 1'b1;
            cs1_n     <= 1'b1;
            r_w_n     <= 1'b1;
            a         <= '0;
            d_out     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop && state != S_MUTE) begin
                // An asserted strobe still gets its full cycle: it is
                // released on this edge, never cut short.
                state     <= S_MUTE;
                mute_step <= '0;
                cnt       <= '0;
                busy      <= 1'b1;
                cs0_n     <= 1'b1;
                cs1_n     <= 1'b1;
                r_w_n     <= 1'b1;
            end else if (start && state != S_MUTE) begin
                pc    <= song_base;
                cnt   <= '0;
                state <= S_FETCH;
                busy  <= 1'b1;
                cs0_n <= 1'b1;
                cs1_n <= 1'b1;
                r_w_n <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        busy <= 1'b0;
                    end
                    S_FETCH: begin
                        state <= S_DECODE;
                    end
                    S_DECODE: begin
                        case (rom_data[15:14])
                            2'b00: begin
                                a     <= rom_data[11:8];
                                d_out <= rom_data[7:0];
                                cs0_n <= 1'b0;
                                cs1_n <= 1'b0;
                                r_w_n <= 1'b0;
                                state <= S_WRITE;
                            end
                            2'b01: begin
                                if (rom_data[7:0] == 8'd0) begin
                                    pc    <= pc + 1'b1;
                                    state <= S_FETCH;
                                end else begin
                                    cnt   <= rom_data[7:0];
                                    state <= S_WAIT;
                                end
                            end
                            2'b10: begin
                                pc    <= rom_data[ROM_AW-1:0];
                                state <= S_FETCH;
                            end
                            default: begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= S_IDLE;
                            end
                        endcase
                    end
                    S_WRITE: begin
                        cs0_n <= 1'b1;
                        cs1_n <= 1'b1;
                        r_w_n <= 1'b1;
                        pc    <= pc + 1'b1;
                        state <= S_FETCH;
                    end
                    S_WAIT: begin
                        if (tick) begin
                            if (cnt == 8'd1) begin
                                cnt   <= '0;
                                pc    <= pc + 1'b1;
                                state <= S_FETCH;
                            end else begin
                                cnt <= cnt - 1'b1;
                            end
                        end
                    end
                    S_MUTE: begin
                        // Even steps raise a strobe to AUDC(n), odd steps
                        // release it, giving one idle cycle between strobes.
                        mute_step <= mute_step + 1'b1;
                        if (!mute_step[0]) begin
                            a     <= {1'b0, mute_step[2:1], 1'b1};
                            d_out <= MUTE_VAL;
                            cs0_n <= 1'b0;
                            cs1_n <= 1'b0;
                            r_w_n <= 1'b0;
                        end else begin
                            cs0_n <= 1'b1;
                            cs1_n <= 1'b1;
                            r_w_n <= 1'b1;
                            if (mute_step == 3'd7) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= S_IDLE;
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
